// File: rtl/set_assoc_data_cache.sv
// set_assoc_data_cache
// N-way set-associative, write-back, write-allocate data cache sitting between
// the CPU load/store port and a block-wide data memory. Lookup is combinational
// so hits complete in the access cycle. Misses are resolved by a three-state
// controller (IDLE -> [WRITEBACK ->] ALLOCATE -> IDLE) that stalls the CPU
// through busywait until the block is resident, after which the held access
// hits normally. Replacement is true LRU using per-way age counters.
//
// Ports
//   clock, reset          system clock; asynchronous active-high reset
//   read, write           CPU request (exactly one high = access), held while busywait
//   address               CPU address {tag, index, offset}
//   writedata             store data
//   readdata              load data, valid while read high and busywait low
//   busywait              CPU stall
//   mem_read, mem_write   block refill / write-back request (never both high)
//   mem_address           block address {tag, index}
//   mem_writedata         victim block, word 0 in LSBs
//   mem_readdata          refill block, word 0 in LSBs
//   mem_busywait          memory busy; a request completes on the first posedge
//                         that samples it low
//
// Handshake: a memory request is held constant from the first cycle it is
// raised until the posedge that samples mem_busywait low; that edge is the
// transfer. The CPU side mirrors this with busywait.
// The controller state is exposed on the internal signal 'state'.
module set_assoc_data_cache #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              read,
  input  logic                              write,
  input  logic [ADDR_W-1:0]                 address,
  input  logic [DATA_W-1:0]                 writedata,
  output logic [DATA_W-1:0]                 readdata,
  output logic                              busywait,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_W-$clog2(WORDS)-1:0]   mem_address,
  output logic [DATA_W*WORDS-1:0]           mem_writedata,
  input  logic [DATA_W*WORDS-1:0]           mem_readdata,
  input  logic                              mem_busywait
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int AGE_W = $clog2(WAYS);
  localparam int BLK_W = DATA_W * WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t state, state_next;

  logic [SETS-1:0][WAYS-1:0] valid, dirty;
  logic [TAG_W-1:0]          tags   [SETS][WAYS];
  logic [BLK_W-1:0]          blocks [SETS][WAYS];
  logic [AGE_W-1:0]          ages   [SETS][WAYS];

  logic [TAG_W-1:0] tag, lat_tag;
  logic [IDX_W-1:0] idx, lat_idx;
  logic [OFF_W-1:0] off;
  logic [AGE_W-1:0] hit_way, victim, lat_way, best_age;
  logic             access, hit, hit_idle, miss_idle, refill;
  logic             touch_en;
  logic [IDX_W-1:0] touch_set;
  logic [AGE_W-1:0] touch_way, touch_old;

  assign tag    = address[ADDR_W-1 -: TAG_W];
  assign idx    = address[OFF_W +: IDX_W];
  assign off    = address[OFF_W-1:0];
  assign access = read ^ write;

  // Tag compare across the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // Victim: lowest-numbered invalid way, else the oldest way.
  always_comb begin
    victim   = '0;
    best_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[idx][w] > best_age) begin
        best_age = ages[idx][w];
        victim   = AGE_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[idx][w]) victim = AGE_W'(w);
    end
  end

  assign hit_idle  = !reset && state == IDLE && access && hit;
  assign miss_idle = !reset && state == IDLE && access && !hit;
  assign refill    = state == ALLOCATE && !mem_busywait;

  assign readdata = (hit_idle && read) ? blocks[idx][hit_way][int'(off)*DATA_W +: DATA_W]
                                       : '0;

  // A refilled way is treated as having been the oldest, so every other way
  // ages by one; this keeps the ages a permutation once the set is full even
  // though all ages start at zero.
  always_comb begin
    touch_en  = hit_idle || refill;
    touch_set = refill ? lat_idx : idx;
    touch_way = refill ? lat_way : hit_way;
    touch_old = refill ? AGE_W'(WAYS - 1) : ages[idx][hit_way];
  end

  always_comb begin
    state_next    = state;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      IDLE: begin
        if (miss_idle) begin
          busywait   = 1'b1;
          state_next = (valid[idx][victim] && dirty[idx][victim]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {tags[lat_idx][lat_way], lat_idx};
        mem_writedata = blocks[lat_idx][lat_way];
        if (!mem_busywait) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {lat_tag, lat_idx};
        if (!mem_busywait) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid   <= '0;
      dirty   <= '0;
      lat_tag <= '0;
      lat_idx <= '0;
      lat_way <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ages[s][w] <= '0;
    end else begin
      state <= state_next;
      if (miss_idle) begin
        lat_tag <= tag;
        lat_idx <= idx;
        lat_way <= victim;
      end
      if (hit_idle && write) dirty[idx][hit_way] <= 1'b1;
      if (refill) begin
        valid[lat_idx][lat_way] <= 1'b1;
        dirty[lat_idx][lat_way] <= 1'b0;
      end
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == touch_way)
            ages[touch_set][w] <= '0;
          else if (ages[touch_set][w] < touch_old)
            ages[touch_set][w] <= ages[touch_set][w] + 1'b1;
        end
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies them.
  always_ff @(posedge clock) begin
    if (hit_idle && write)
      blocks[idx][hit_way][int'(off)*DATA_W +: DATA_W] <= writedata;
    if (refill) begin
      blocks[lat_idx][lat_way] <= mem_readdata;
      tags[lat_idx][lat_way]   <= lat_tag;
    end
  end
endmodule
